// File: rtl/posit_data_extraction.sv
// Registered posit field decoder: splits an N-bit posit into sign, regime value k,
// exponent and hidden-bit mantissa, with one output register stage.
module posit_data_extraction #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic [N-1:0]        In,
    input  logic                InValid,
    output logic                OutValid,
    output logic                Sign,
    output logic signed [RS:0]  RegimeValue,
    output logic [ES-1:0]       Exponent,
    output logic [N-ES+2:0]     Mantissa,
    output logic                Zero,
    output logic                NaR
);

    localparam int FW = N - 1 - ES;

    logic [N-1:0]        abs_w;
    logic [N-2:0]        body;
    logic [N-2:0]        run_x;
    logic                reg_bit;
    logic                stop;
    logic [RS:0]         run;
    logic [N-2:0]        shifted;
    logic                is_zero;
    logic                is_nar;

    logic                valid_d, valid_q;
    logic                sign_d, sign_q;
    logic signed [RS:0]  regime_d, regime_q;
    logic [ES-1:0]       exp_d, exp_q;
    logic [N-ES+2:0]     mant_d, mant_q;
    logic                zero_d, zero_q;
    logic                nar_d, nar_q;

    assign abs_w   = In[N-1] ? (~In + N'(1)) : In;
    assign body    = abs_w[N-2:0];
    assign reg_bit = body[N-2];
    // XOR with the regime bit turns the regime run into a leading-zero run.
    assign run_x   = body ^ {(N-1){reg_bit}};
    assign is_zero = (In == '0);
    assign is_nar  = (In == {1'b1, {(N-1){1'b0}}});

    always_comb begin
        run  = '0;
        stop = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop) begin
                if (run_x[i]) stop = 1'b1;
                else          run  = run + (RS+1)'(1);
            end
        end
    end

    // Drop the run and its terminator; a run reaching the LSB shifts everything out.
    assign shifted = body << (run + (RS+1)'(1));

    always_comb begin
        valid_d  = InValid;
        sign_d   = In[N-1];
        regime_d = reg_bit ? $signed(run - (RS+1)'(1)) : -$signed(run);
        exp_d    = shifted[N-2 -: ES];
        mant_d   = {1'b1, shifted[FW-1:0], 3'b000};
        zero_d   = is_zero;
        nar_d    = is_nar;
        if (is_zero) begin
            mant_d = '0;
        end
        if (is_nar) begin
            regime_d = '0;
            mant_d   = '0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            valid_q  <= 1'b0;
            sign_q   <= 1'b0;
            regime_q <= '0;
            exp_q    <= '0;
            mant_q   <= '0;
            zero_q   <= 1'b0;
            nar_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (InValid) begin
                sign_q   <= sign_d;
                regime_q <= regime_d;
                exp_q    <= exp_d;
                mant_q   <= mant_d;
                zero_q   <= zero_d;
                nar_q    <= nar_d;
            end
        end
    end

    assign OutValid    = valid_q;
    assign Sign        = sign_q;
    assign RegimeValue = regime_q;
    assign Exponent    = exp_q;
    assign Mantissa    = mant_q;
    assign Zero        = zero_q;
    assign NaR         = nar_q;

endmodule

// File: tb/tb_posit_data_extraction.sv
// Scoreboard bench for posit_data_extraction (N=8, ES=3) with an arithmetic reference model.
module tb_posit_data_extraction;

    localparam int N  = 8;
    localparam int ES = 3;
    localparam int RS = 3;
    localparam int MW = N - ES + 3;

    logic                Clock = 1'b0;
    logic                nReset = 1'b0;
    logic [N-1:0]        In = '0;
    logic                InValid = 1'b0;
    logic                OutValid;
    logic                Sign;
    logic signed [RS:0]  RegimeValue;
    logic [ES-1:0]       Exponent;
    logic [MW-1:0]       Mantissa;
    logic                Zero;
    logic                NaR;

    typedef struct {
        bit  vld;
        int  sign;
        int  k;
        int  e;
        int  mant;
        int  zero;
        int  nar;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   failures = 0;

    posit_data_extraction #(.N(N), .ES(ES)) dut (
        .Clock(Clock), .nReset(nReset), .In(In), .InValid(InValid),
        .OutValid(OutValid), .Sign(Sign), .RegimeValue(RegimeValue),
        .Exponent(Exponent), .Mantissa(Mantissa), .Zero(Zero), .NaR(NaR)
    );

    always #5 Clock = ~Clock;

    function automatic exp_t model(input int w);
        exp_t x;
        int mask, v, body, r, t, bl, m, L, rem, flen, frac;
        mask = (1 << (N - 1)) - 1;
        x.vld = 1'b1; x.zero = 0; x.nar = 0;
        if (w == 0) begin
            x.sign = 0; x.k = -(N - 1); x.e = 0; x.mant = 0; x.zero = 1;
            return x;
        end
        if (w == (1 << (N - 1))) begin
            x.sign = 1; x.k = 0; x.e = 0; x.mant = 0; x.nar = 1;
            return x;
        end
        x.sign = (w >> (N - 1)) & 1;
        v    = x.sign ? ((1 << N) - w) : w;
        body = v & mask;
        r    = (body >> (N - 2)) & 1;
        t    = r ? (~body & mask) : body;
        bl   = 0;
        while ((t >> bl) != 0) bl++;
        m    = (N - 1) - bl;
        x.k  = r ? m - 1 : -m;
        L    = N - 2 - m;
        if (L < 0) L = 0;
        rem  = body & ((1 << L) - 1);
        if (L >= ES) begin
            x.e  = rem >> (L - ES);
            flen = L - ES;
            frac = rem & ((1 << flen) - 1);
        end else begin
            x.e  = rem << (ES - L);
            flen = 0;
            frac = 0;
        end
        x.mant = ((1 << flen) | frac) << (MW - 1 - flen);
        return x;
    endfunction

    function automatic exp_t zero_state();
        exp_t x;
        x.vld = 1'b0; x.sign = 0; x.k = 0; x.e = 0; x.mant = 0; x.zero = 0; x.nar = 0;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_fields(input string tag, input exp_t x);
        check({tag, ".Sign"},     int'(Sign),        x.sign);
        check({tag, ".Regime"},   int'(RegimeValue), x.k);
        check({tag, ".Exponent"}, int'(Exponent),    x.e);
        check({tag, ".Mantissa"}, int'(Mantissa),    x.mant);
        check({tag, ".Zero"},     int'(Zero),        x.zero);
        check({tag, ".NaR"},      int'(NaR),         x.nar);
    endtask

    // Monitor: one scoreboard entry per cycle; idle entries expect the last decode held.
    initial begin
        last = zero_state();
        forever begin
            @(negedge Clock);
            if (nReset && q.size() > 0) begin
                exp_t x;
                x = q.pop_front();
                check("OutValid", int'(OutValid), int'(x.vld));
                if (x.vld) begin
                    check_fields("decode", x);
                    last = x;
                end else begin
                    check_fields("hold", last);
                end
            end
        end
    end

    task automatic drive(input bit vld, input logic [N-1:0] w);
        exp_t x;
        @(negedge Clock);
        #1;
        In      = w;
        InValid = vld;
        if (vld) x = model(int'(w));
        else     x = zero_state();
        q.push_back(x);
    endtask

    initial begin
        logic [7:0] directed [6];
        directed[0] = 8'b0000_0000;
        directed[1] = 8'b1011_0000;
        directed[2] = 8'b0000_1101;
        directed[3] = 8'b0000_0011;
        directed[4] = 8'b0111_1111;
        directed[5] = 8'b1000_0000;

        repeat (2) @(negedge Clock);
        check_fields("por", zero_state());
        check("por.OutValid", int'(OutValid), 0);
        #3 nReset = 1'b1;

        repeat (3) drive(1'b0, '0);
        foreach (directed[i]) drive(1'b1, directed[i]);
        drive(1'b0, 8'h55);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h81);
        drive(1'b1, 8'h7F);
        drive(1'b1, 8'h4A);
        drive(1'b1, 8'hC3);
        repeat (3) drive(1'b0, 8'h00);
        for (int i = 0; i < 200; i++) drive(($urandom_range(0, 3) != 0), 8'($urandom));

        // Asynchronous reset mid-stream, while a word is being presented.
        drive(1'b1, 8'h7F);
        drive(1'b1, 8'h29);
        #2 nReset = 1'b0;
        #1;
        check_fields("async_rst", zero_state());
        check("async_rst.OutValid", int'(OutValid), 0);
        q.delete();
        last = zero_state();
        InValid = 1'b0;
        @(negedge Clock);
        #3 nReset = 1'b1;
        repeat (3) drive(1'b0, 8'h3C);
        for (int i = 0; i < 60; i++) drive(($urandom_range(0, 1) != 0), 8'($urandom));
        drive(1'b1, 8'h12);
        drive(1'b1, 8'hE7);
        drive(1'b1, 8'h40);
        repeat (3) drive(1'b0, 8'h99);

        repeat (2) @(negedge Clock);
        #2;
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
